// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Main decoder for the 64-bit RISC-V style datapath. The 7-bit opcode field
// instr[6:0] is decoded into the datapath control signals. Every output is
// registered: it loads the decode of the opcode sampled on the rising clock
// edge and holds that value until the next edge.
//
// Ports
//   ALUOp    out [ALUOP_W-1:0]  00 add (address calc), 01 subtract/compare
//                               (branch), 10 R-type, 11 I-type ALU
//   branch   out                conditional-branch instruction
//   memWrite out                data-memory write enable
//   memRead  out                data-memory read enable
//   regWrite out                register-file write enable
//   memToReg out                write-back select: 1 = memory, 0 = ALU result
//   ALUsrc   out                ALU operand B select: 1 = immediate, 0 = rs2
//   instr    in  [OPC_W-1:0]    opcode field instr[6:0]
//   clk      in                 system clock, rising-edge active
//   reset    in                 asynchronous, active-high; clears all outputs
// -----------------------------------------------------------------------------
module control_unit #(
   parameter int OPC_W   = 7,
   parameter int ALUOP_W = 2
) (
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               branch,
   output logic               memWrite,
   output logic               memRead,
   output logic               regWrite,
   output logic               memToReg,
   output logic               ALUsrc,
   input  logic [OPC_W-1:0]   instr,
   input  logic               clk,
   input  logic               reset
);

   // Opcodes recognised by the decoder. Only an exact 7-bit match selects a row.
   localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'h33;
   localparam logic [OPC_W-1:0] OPC_IALU   = 7'h13;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;

   // ALUOp encodings consumed by the downstream ALU-control decoder.
   localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYP = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_ITYP = 2'b11;

   logic [ALUOP_W-1:0] aluop_d,    aluop_q;
   logic               branch_d,   branch_q;
   logic               memwrite_d, memwrite_q;
   logic               memread_d,  memread_q;
   logic               regwrite_d, regwrite_q;
   logic               memtoreg_d, memtoreg_q;
   logic               alusrc_d,   alusrc_q;

   // Combinational decode. Every signal defaults to 0 so unknown opcodes
   // decode to a NOP with no register or memory side effects.
   always_comb begin
      aluop_d    = ALUOP_ADD;
      branch_d   = 1'b0;
      memwrite_d = 1'b0;
      memread_d  = 1'b0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      alusrc_d   = 1'b0;
      case (instr)
         OPC_RTYPE: begin
            regwrite_d = 1'b1;
            aluop_d    = ALUOP_RTYP;
         end
         OPC_IALU: begin
            alusrc_d   = 1'b1;
            regwrite_d = 1'b1;
            aluop_d    = ALUOP_ITYP;
         end
         OPC_LOAD: begin
            alusrc_d   = 1'b1;
            memtoreg_d = 1'b1;
            regwrite_d = 1'b1;
            memread_d  = 1'b1;
            aluop_d    = ALUOP_ADD;
         end
         OPC_STORE: begin
            alusrc_d   = 1'b1;
            memwrite_d = 1'b1;
            aluop_d    = ALUOP_ADD;
         end
         OPC_BRANCH: begin
            branch_d   = 1'b1;
            aluop_d    = ALUOP_SUB;
         end
         default: ;
      endcase
   end

   // Output registers; reset clears them immediately, independent of clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aluop_q    <= '0;
         branch_q   <= 1'b0;
         memwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
      end else begin
         aluop_q    <= aluop_d;
         branch_q   <= branch_d;
         memwrite_q <= memwrite_d;
         memread_q  <= memread_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         alusrc_q   <= alusrc_d;
      end
   end

   assign ALUOp    = aluop_q;
   assign branch   = branch_q;
   assign memWrite = memwrite_q;
   assign memRead  = memread_q;
   assign regWrite = regwrite_q;
   assign memToReg = memtoreg_q;
   assign ALUsrc   = alusrc_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Self-checking bench for control_unit. Outputs are packed as
// {ALUsrc, memToReg, regWrite, memRead, memWrite, branch, ALUOp[1:0]} and
// compared against a reference decode built from per-signal rules.
// -----------------------------------------------------------------------------
module tb_control_unit;

   logic [1:0] ALUOp;
   logic       branch, memWrite, memRead, regWrite, memToReg, ALUsrc;
   logic [6:0] instr;
   logic       clk;
   logic       reset;

   int n_checks;
   int n_fail;

   logic [7:0] exp_q;   // expected registered outputs

   control_unit dut (
      .ALUOp    (ALUOp),
      .branch   (branch),
      .memWrite (memWrite),
      .memRead  (memRead),
      .regWrite (regWrite),
      .memToReg (memToReg),
      .ALUsrc   (ALUsrc),
      .instr    (instr),
      .clk      (clk),
      .reset    (reset)
   );

   function automatic logic [7:0] outs();
      return {ALUsrc, memToReg, regWrite, memRead, memWrite, branch, ALUOp};
   endfunction

   // Reference decode: each control signal is the set of instruction
   // classes that need it.
   function automatic logic [7:0] ref_decode(input logic [6:0] op);
      bit is_r, is_i, is_ld, is_st, is_br;
      logic [1:0] aop;
      is_r  = (op == 7'h33);
      is_i  = (op == 7'h13);
      is_ld = (op == 7'h03);
      is_st = (op == 7'h23);
      is_br = (op == 7'h63);
      aop = 2'd0;
      if (is_r)  aop = 2'd2;
      if (is_i)  aop = 2'd3;
      if (is_br) aop = 2'd1;
      return {(is_i | is_ld | is_st),   // ALUsrc: uses immediate
              is_ld,                    // memToReg
              (is_r | is_i | is_ld),    // regWrite
              is_ld,                    // memRead
              is_st,                    // memWrite
              is_br,                    // branch
              aop};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, want);
      end
   endtask

   // One full clock period; returns with clk low, well away from the edge.
   task automatic tick();
      #4 clk = 1'b1;
      if (reset) exp_q = 8'h00;
      else       exp_q = ref_decode(instr);
      #5 clk = 1'b0;
      #1;
   endtask

   task automatic apply(input logic [6:0] op, input string tag);
      instr = op;
      tick();
      check(tag, outs(), exp_q);
   endtask

   logic [6:0] legal [5];

   initial begin
      legal[0] = 7'h33; legal[1] = 7'h13; legal[2] = 7'h03;
      legal[3] = 7'h23; legal[4] = 7'h63;
      n_checks = 0;
      n_fail   = 0;
      clk   = 1'b0;
      reset = 1'b0;
      instr = 7'h00;
      exp_q = 8'h00;

      // Reset, then release with no clock edge.
      #1 reset = 1'b1;
      #3 check("reset_asserted", outs(), 8'h00);
      reset = 1'b0;
      #3 check("reset_released_no_edge", outs(), 8'h00);

      // Directed decode rows with fixed expected values.
      instr = 7'h33; tick(); check("rtype", outs(), 8'b0010_0010);
      instr = 7'h33; tick(); check("rtype_again", outs(), 8'b0010_0010);
      instr = 7'h03; tick(); check("load", outs(), 8'b1111_0000);
      instr = 7'h23; tick(); check("store", outs(), 8'b1000_1000);
      instr = 7'h63; tick(); check("branch", outs(), 8'b0000_0101);
      instr = 7'h13; tick(); check("ialu", outs(), 8'b1010_0011);
      instr = 7'h47; tick(); check("illegal_47", outs(), 8'h00);
      instr = 7'h05; tick(); check("illegal_05", outs(), 8'h00);
      // Near misses of legal opcodes (one bit off) decode as NOP.
      apply(7'h73, "near_rtype");
      apply(7'h02, "near_load");
      apply(7'h62, "near_branch");

      // Hold between edges, then asynchronous reset between edges.
      instr = 7'h03; tick(); check("load_hold_setup", outs(), 8'b1111_0000);
      instr = 7'h33;
      #2 check("hold_no_edge", outs(), 8'b1111_0000);
      reset = 1'b1;
      #1 check("async_reset_mid", outs(), 8'h00);
      tick(); check("edge_during_reset", outs(), 8'h00);
      reset = 1'b0;
      #2 check("after_release_no_edge", outs(), 8'h00);
      instr = 7'h13; tick(); check("resume_ialu", outs(), 8'b1010_0011);

      // Randomized stimulus against the reference decode.
      for (int i = 0; i < 400; i++) begin
         logic [6:0] op;
         logic [7:0] o;
         if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 4)];
         else                           op = 7'($urandom_range(0, 127));
         apply(op, "rand_decode");
         o = outs();
         check("rand_rd_wr_excl", {7'd0, o[4] & o[3]}, 8'h00);
         check("rand_br_no_wr",   {7'd0, o[2] & o[5]}, 8'h00);
         if ($urandom_range(0, 3) == 0) begin
            instr = 7'($urandom);
            #2 check("rand_hold", outs(), exp_q);
         end
         if ($urandom_range(0, 9) == 0) begin
            #1 reset = 1'b1;
            exp_q = 8'h00;
            #1 check("rand_async_reset", outs(), 8'h00);
            reset = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
